fso_deframer: RTL and testbench

Receive-side frame delineator for the FSO link. It sits directly downstream of `fso_framer` on the RX path and accepts the same 32-bit word stream the framer produces. It hunts for and verifies the sync word, then parses the frame header. It descrambles the payload and delivers payload words with a block-start marker to the downstream decoder, using a valid/ready handshake on both sides.

---
 rtl/fso_pkg.sv | 22 ++
 rtl/fso_descrambler.sv | 27 ++
 rtl/fso_deframer.sv | 174 +++++++++++++++++
 tb/tb_fso_deframer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fso_pkg.sv
// Shared constants and types for the FSO link deframer: sync word, PRBS15
// descrambler parameters, header field widths and the delineation states.
package fso_pkg;

    localparam logic [31:0] SYNC_WORD = 32'h1ACF_FC1D;

    localparam int          PRBS_W     = 15;
    localparam logic [14:0] PRBS_SEED  = 15'h7FFF;
    localparam int          PRBS_TAP_A = 14;
    localparam int          PRBS_TAP_B = 13;

    localparam int HDR_FIB_W = 16;
    localparam int HDR_BID_W = 16;

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        HDR      = 2'd1,
        PLD      = 2'd2,
        SYNC_CHK = 2'd3
    } state_e;

endpackage

// File: rtl/fso_descrambler.sv
// PRBS15 (x^15+x^14+1) descrambler for one 32-bit word, fully unrolled.
// The first generated bit lands on data bit 31; the caller holds the state.
module fso_descrambler
    import fso_pkg::*;
(
    input  logic [PRBS_W-1:0] i_state,
    input  logic [31:0]       i_data,
    output logic [PRBS_W-1:0] o_state,
    output logic [31:0]       o_data
);

    logic [PRBS_W-1:0] s;
    logic              fb;

    always_comb begin
        s      = i_state;
        fb     = 1'b0;
        o_data = i_data;
        for (int i = 31; i >= 0; i--) begin
            fb        = s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
            o_data[i] = i_data[i] ^ fb;
            s         = {s[PRBS_W-2:0], fb};
        end
        o_state = s;
    end

endmodule

// File: rtl/fso_deframer.sv
// RX frame delineator: hunts the sync word, keeps lock with a flywheel,
// parses the header and hands descrambled payload words downstream.
module fso_deframer
    import fso_pkg::*;
#(
    parameter int W                = 32,
    parameter int PAYLOAD_WORDS    = 16,
    parameter int FRAMES_PER_BLOCK = 255,
    parameter int LOCK_FRAMES      = 3,
    parameter int LOSS_FRAMES      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    input  logic         descrambler_en,
    output logic [W-1:0] o_payload_data,
    output logic         o_payload_valid,
    input  logic         i_payload_ready,
    output logic         o_payload_block_start,
    output logic         o_locked,
    output logic [15:0]  o_frame_in_block,
    output logic [15:0]  o_block_id,
    output logic [15:0]  o_sync_err_cnt
);

    localparam int WCNT_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

    state_e               state_q, state_d;
    logic                 locked_q, locked_d;
    logic [3:0]           good_cnt_q, good_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [PRBS_W-1:0]    lfsr_q, lfsr_d, lfsr_nxt;
    logic [W-1:0]         pdata_q, pdata_d, descr_data;
    logic                 pvalid_q, pvalid_d, pbs_q, pbs_d;
    logic [HDR_BID_W-1:0] block_id_q, block_id_d;
    logic [HDR_FIB_W-1:0] fib_q, fib_d;
    logic [15:0]          err_q, err_d;

    logic       accept, sync_match, hdr_bad, pld_last, loss;
    logic [3:0] good_inc, miss_inc;

    assign o_rx_ready = !pvalid_q || i_payload_ready;
    assign accept     = i_rx_valid && o_rx_ready;
    assign sync_match = (i_rx_data == SYNC_WORD);
    assign hdr_bad    = i_rx_data[HDR_FIB_W-1:0] >= HDR_FIB_W'(FRAMES_PER_BLOCK);
    assign pld_last   = (wcnt_q == WCNT_W'(PAYLOAD_WORDS - 1));
    assign good_inc   = (good_cnt_q == 4'hF) ? good_cnt_q : good_cnt_q + 4'd1;
    assign miss_inc   = (miss_cnt_q == 4'hF) ? miss_cnt_q : miss_cnt_q + 4'd1;
    assign loss       = locked_q && (miss_inc >= 4'(LOSS_FRAMES));

    assign o_payload_data        = pdata_q;
    assign o_payload_valid       = pvalid_q;
    assign o_payload_block_start = pbs_q;
    assign o_locked              = locked_q;
    assign o_block_id            = block_id_q;
    assign o_frame_in_block      = fib_q;
    assign o_sync_err_cnt        = err_q;

    fso_descrambler u_descr (
        .i_state (lfsr_q),
        .i_data  (i_rx_data),
        .o_state (lfsr_nxt),
        .o_data  (descr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEARCH;
            locked_q   <= 1'b0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
            wcnt_q     <= '0;
            lfsr_q     <= '0;
            pdata_q    <= '0;
            pvalid_q   <= 1'b0;
            pbs_q      <= 1'b0;
            block_id_q <= '0;
            fib_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wcnt_q     <= wcnt_d;
            lfsr_q     <= lfsr_d;
            pdata_q    <= pdata_d;
            pvalid_q   <= pvalid_d;
            pbs_q      <= pbs_d;
            block_id_q <= block_id_d;
            fib_q      <= fib_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                SEARCH:   if (sync_match) state_d = HDR;
                HDR:      state_d = hdr_bad ? SEARCH : PLD;
                PLD:      if (pld_last) state_d = SYNC_CHK;
                // A missed sync while locked is flywheeled as if it were the sync
                SYNC_CHK: state_d = (sync_match || (locked_q && !loss)) ? HDR : SEARCH;
                default:  state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked_d   = locked_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wcnt_d     = wcnt_q;
        lfsr_d     = lfsr_q;
        pdata_d    = pdata_q;
        pvalid_d   = pvalid_q;
        pbs_d      = pbs_q;
        block_id_d = block_id_q;
        fib_d      = fib_q;
        err_d      = err_q;
        if (pvalid_q && i_payload_ready) begin
            pvalid_d = 1'b0;
            pbs_d    = 1'b0;
        end
        if (accept) begin
            case (state_q)
                SEARCH: if (sync_match) good_cnt_d = 4'd1;
                HDR: begin
                    if (hdr_bad) begin
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                        miss_cnt_d = '0;
                    end else begin
                        block_id_d = i_rx_data[W-1 -: HDR_BID_W];
                        fib_d      = i_rx_data[HDR_FIB_W-1:0];
                        wcnt_d     = '0;
                        lfsr_d     = PRBS_SEED;
                    end
                end
                PLD: begin
                    wcnt_d = wcnt_q + 1'b1;
                    lfsr_d = lfsr_nxt;
                    if (locked_q) begin
                        pdata_d  = descrambler_en ? descr_data : i_rx_data;
                        pvalid_d = 1'b1;
                        pbs_d    = (fib_q == '0) && (wcnt_q == '0);
                    end
                end
                SYNC_CHK: begin
                    if (sync_match) begin
                        miss_cnt_d = '0;
                        if (!locked_q) begin
                            good_cnt_d = good_inc;
                            if (good_inc >= 4'(LOCK_FRAMES)) locked_d = 1'b1;
                        end
                    end else begin
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        if (locked_q) begin
                            miss_cnt_d = loss ? 4'd0 : miss_inc;
                            if (loss) locked_d = 1'b0;
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fso_deframer.sv
// Scoreboard bench for fso_deframer: frame-level reference model of lock,
// header and keystream behaviour feeding an expected-output queue.
module tb_fso_deframer;
    import fso_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic        descrambler_en = 1'b0;
    logic [31:0] o_payload_data;
    logic        o_payload_valid;
    logic        i_payload_ready = 1'b1;
    logic        o_payload_block_start;
    logic        o_locked;
    logic [15:0] o_frame_in_block, o_block_id, o_sync_err_cnt;

    fso_deframer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_rx_data             (i_rx_data),
        .i_rx_valid            (i_rx_valid),
        .o_rx_ready            (o_rx_ready),
        .descrambler_en        (descrambler_en),
        .o_payload_data        (o_payload_data),
        .o_payload_valid       (o_payload_valid),
        .i_payload_ready       (i_payload_ready),
        .o_payload_block_start (o_payload_block_start),
        .o_locked              (o_locked),
        .o_frame_in_block      (o_frame_in_block),
        .o_block_id            (o_block_id),
        .o_sync_err_cnt        (o_sync_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        bs;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rnd_rdy = 1'b0;
    bit          gaps = 1'b0;
    bit          ks[0:526];
    logic [31:0] pay[16];

    // frame-level reference state
    bit          m_hunt = 1'b1;
    bit          m_locked = 1'b0;
    int          m_good = 0;
    int          m_miss = 0;
    int          m_err = 0;
    logic [15:0] m_bid = '0;
    logic [15:0] m_fib = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // keystream as the sequence x[n] = x[n-15] ^ x[n-14], x[-1..-15] = seed bits
    function automatic logic [31:0] key(input int i);
        logic [31:0] k;
        for (int j = 0; j < 32; j++) k[31-j] = ks[15 + 32*i + j];
        return k;
    endfunction

    function automatic bit model_sync(input bit ok);
        if (m_hunt) begin
            if (ok) begin
                m_hunt = 1'b0;
                m_good = 1;
                return 1'b1;
            end
            return 1'b0;
        end
        if (ok) begin
            m_miss = 0;
            if (!m_locked) begin
                m_good++;
                if (m_good >= 3) m_locked = 1'b1;
            end
            return 1'b1;
        end
        m_err++;
        if (!m_locked) begin
            m_good = 0;
            m_hunt = 1'b1;
            return 1'b0;
        end
        m_miss++;
        if (m_miss >= 4) begin
            m_locked = 1'b0;
            m_miss = 0;
            m_hunt = 1'b1;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic send_word(input logic [31:0] w);
        int budget;
        budget = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        i_rx_data  = w;
        i_rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (o_rx_ready) begin
                @(posedge clk);
                #1;
                i_rx_valid = 1'b0;
                break;
            end
            budget++;
            if (budget > 1000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_ready_timeout: got stalled expected ready within 1000 cycles");
                i_rx_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", 32'(o_payload_valid), 32'd0);
        chk("rst_data", o_payload_data, 32'd0);
        chk("rst_bs", 32'(o_payload_block_start), 32'd0);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_fib", 32'(o_frame_in_block), 32'd0);
        chk("rst_bid", 32'(o_block_id), 32'd0);
        chk("rst_err", 32'(o_sync_err_cnt), 32'd0);
        chk("rst_ready", 32'(o_rx_ready), 32'd1);
    endtask

    task automatic reset_mid(input logic [31:0] w);
        i_rx_data  = w;
        i_rx_valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (3) @(posedge clk);
        q.delete();
        m_hunt = 1'b1; m_locked = 1'b0; m_good = 0; m_miss = 0; m_err = 0;
        m_bid = '0; m_fib = '0;
        @(negedge clk);
        rst_n      = 1'b1;
        i_rx_valid = 1'b0;
        #1 chk_reset_outputs();
    endtask

    task automatic send_frame(input logic [31:0] sync, input logic [15:0] bid,
                              input logic [15:0] fib, input bit en, input bit scr,
                              input int stop_at);
        logic [31:0] w;
        bit          take;
        exp_t        e;
        descrambler_en = en;
        send_word(sync);
        take = model_sync(sync == SYNC_WORD);
        chk("locked_after_sync", 32'(o_locked), 32'(m_locked));
        send_word({bid, fib});
        if (take) begin
            if (fib >= 16'd255) begin
                m_locked = 1'b0; m_good = 0; m_miss = 0; m_hunt = 1'b1;
                take = 1'b0;
            end else begin
                m_bid = bid;
                m_fib = fib;
            end
        end
        chk("locked_after_hdr", 32'(o_locked), 32'(m_locked));
        chk("block_id", 32'(o_block_id), 32'(m_bid));
        chk("frame_in_block", 32'(o_frame_in_block), 32'(m_fib));
        for (int i = 0; i < 16; i++) begin
            if (i == stop_at) begin
                reset_mid(pay[i]);
                return;
            end
            w = scr ? (pay[i] ^ key(i)) : pay[i];
            if (w == SYNC_WORD) w = w ^ 32'd1;
            send_word(w);
            if (take && m_locked) begin
                e.data = en ? (w ^ key(i)) : w;
                e.bs   = (i == 0) && (m_fib == 16'd0);
                q.push_back(e);
            end
        end
        chk("sync_err_cnt", 32'(o_sync_err_cnt), 32'(m_err));
    endtask

    // ready driver: always-ready or 50% random
    initial begin
        forever begin
            @(posedge clk);
            #1 i_payload_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: pop on every output transfer, check hold while stalled
    initial begin
        bit          hold_v;
        logic [31:0] hold_d;
        logic        hold_bs;
        exp_t        e;
        hold_v = 1'b0;
        hold_d = '0;
        hold_bs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
                continue;
            end
            if (hold_v) begin
                chk("hold_valid", 32'(o_payload_valid), 32'd1);
                chk("hold_data", o_payload_data, hold_d);
                chk("hold_bs", 32'(o_payload_block_start), 32'(hold_bs));
            end
            hold_v = 1'b0;
            if (o_payload_valid) begin
                if (i_payload_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got %h expected no word", o_payload_data);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", o_payload_data, e.data);
                        chk("out_block_start", 32'(o_payload_block_start), 32'(e.bs));
                    end
                end else begin
                    hold_v  = 1'b1;
                    hold_d  = o_payload_data;
                    hold_bs = o_payload_block_start;
                end
            end
        end
    end

    initial begin
        int budget;
        for (int j = 0; j < 15; j++) ks[14-j] = PRBS_SEED[j];
        for (int n = 15; n < 527; n++) ks[n] = ks[n-15] ^ ks[n-14];

        repeat (3) @(posedge clk);
        #1 chk_reset_outputs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk_reset_outputs();

        // lock acquisition, bypass mode, payload = index
        for (int i = 0; i < 16; i++) pay[i] = 32'(i);
        for (int f = 0; f < 4; f++) send_frame(SYNC_WORD, 16'h0001, 16'(f), 1'b0, 1'b0, -1);

        // descrambler: scrambled DEADBEEF must come back as DEADBEEF
        for (int i = 0; i < 16; i++) pay[i] = 32'hDEAD_BEEF;
        for (int f = 4; f < 6; f++) send_frame(SYNC_WORD, 16'h0002, 16'(f), 1'b1, 1'b1, -1);

        // backpressure with random traffic
        rnd_rdy = 1'b1;
        gaps    = 1'b1;
        for (int f = 6; f < 12; f++) begin
            bit en;
            en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) pay[i] = $urandom;
            send_frame(SYNC_WORD, 16'h0003, 16'(f), en, en, -1);
        end

        // flywheel over 3 misses, then loss after 4
        for (int f = 0; f < 3; f++) send_frame(SYNC_WORD ^ 32'h0000_0100, 16'h0004, 16'(20 + f), 1'b0, 1'b0, -1);
        send_frame(SYNC_WORD, 16'h0004, 16'd23, 1'b1, 1'b0, -1);
        for (int f = 0; f < 4; f++) send_frame(~SYNC_WORD, 16'h0004, 16'(24 + f), 1'b0, 1'b0, -1);
        for (int f = 0; f < 3; f++) send_frame(SYNC_WORD, 16'h0004, 16'(30 + f), 1'b1, 1'b1, -1);

        // block boundary and invalid frame_in_block
        send_frame(SYNC_WORD, 16'h0005, 16'd254, 1'b0, 1'b0, -1);
        send_frame(SYNC_WORD, 16'h0006, 16'd0, 1'b0, 1'b0, -1);
        send_frame(SYNC_WORD, 16'h0007, 16'd255, 1'b0, 1'b0, -1);
        for (int f = 0; f < 3; f++) send_frame(SYNC_WORD, 16'h0008, 16'(f), 1'b1, 1'b1, -1);

        // reset during payload word 7 of a locked frame, then relock
        send_frame(SYNC_WORD, 16'h0009, 16'd3, 1'b0, 1'b0, 7);
        for (int f = 0; f < 4; f++) send_frame(SYNC_WORD, 16'h000A, 16'(f), 1'b1, 1'b1, -1);

        rnd_rdy = 1'b0;
        budget  = 0;
        while (q.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
